// File: rtl/backend_pkg.sv
// Shared backend definitions: SPI frame size, poll word, SPI slave states.
package backend_pkg;

  localparam int          SPI_WORD_W    = 32;
  localparam logic [31:0] SPI_POLL_WORD = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } spi_state_t;

endpackage

// File: rtl/sync_bits.sv
// Multi-bit flop-chain synchronizer with a per-bit reset preset value.
module sync_bits #(
  parameter int               WIDTH  = 1,
  parameter int               DEPTH  = 2,
  parameter logic [WIDTH-1:0] PRESET = '0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_mask,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [DEPTH];

  always_ff @(posedge sys_clk or negedge sys_rst_mask) begin
    if (!sys_rst_mask) begin
      for (int i = 0; i < DEPTH; i++) r_sync[i] <= PRESET;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/gigex_spi_slave.sv
// SPI slave toward the GigEx: receives command words, returns held response.
module gigex_spi_slave
  import backend_pkg::*;
#(
  parameter int WORD_W      = SPI_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_mask,
  input  logic              spi_cs,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [WORD_W-1:0] cmd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic [WORD_W-1:0] rsp_data,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  output logic              overrun
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [WORD_W-1:0] POLL = WORD_W'(SPI_POLL_WORD);

  logic [2:0] w_sync;
  logic       w_cs, w_sck, w_mosi;

  sync_bits #(
    .WIDTH (3),
    .DEPTH (SYNC_STAGES),
    .PRESET(3'b110)
  ) u_sync (
    .sys_clk     (sys_clk),
    .sys_rst_mask(sys_rst_mask),
    .i_d         ({spi_cs, spi_sck, spi_mosi}),
    .o_q         (w_sync)
  );

  assign {w_cs, w_sck, w_mosi} = w_sync;

  spi_state_t       r_state;
  logic             r_cs_q, r_sck_q;
  logic [SYNC_STAGES:0] r_arm;
  logic [CW-1:0]    r_cnt;
  logic [WORD_W-1:0] r_rx, r_miso_sr;
  logic [WORD_W-1:0] r_hold, r_cmd_data;
  logic             r_full, r_rdy, r_from_hold;
  logic             r_cmd_valid, r_overrun;

  logic              w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;
  logic              w_last, w_load, w_consume, w_full_nxt;
  logic [WORD_W-1:0] w_word;

  // cs fall is ignored until the synchronizers have flushed after reset,
  // so a frame already running at release is never picked up mid-way.
  assign w_cs_fall  = r_arm[SYNC_STAGES] & r_cs_q & ~w_cs;
  assign w_cs_rise  = ~r_cs_q & w_cs;
  assign w_sck_rise = ~r_sck_q & w_sck;
  assign w_sck_fall = r_sck_q & ~w_sck;
  assign w_word     = {r_rx[WORD_W-2:0], w_mosi};

  always_comb begin
    w_last     = (r_state == ST_SHIFT) & ~w_cs_rise & w_sck_rise
               & (r_cnt == CW'(WORD_W - 1));
    w_load     = rsp_valid & r_rdy;
    w_consume  = w_last & r_from_hold;
    w_full_nxt = (r_full & ~w_consume) | w_load;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_mask) begin
    if (!sys_rst_mask) begin
      r_state     <= ST_IDLE;
      r_cs_q      <= 1'b1;
      r_sck_q     <= 1'b1;
      r_arm       <= '0;
      r_cnt       <= '0;
      r_rx        <= '0;
      r_miso_sr   <= '0;
      r_hold      <= '0;
      r_full      <= 1'b0;
      r_rdy       <= 1'b0;
      r_from_hold <= 1'b0;
      r_cmd_data  <= '0;
      r_cmd_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_cs_q  <= w_cs;
      r_sck_q <= w_sck;
      r_arm   <= {r_arm[SYNC_STAGES-1:0], 1'b1};
      r_full  <= w_full_nxt;
      r_rdy   <= ~w_full_nxt;
      if (w_load) r_hold <= rsp_data;
      if (r_cmd_valid && cmd_ready) r_cmd_valid <= 1'b0;

      if (w_cs_rise) begin
        r_state <= ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_cs_fall) begin
              r_state     <= ST_SHIFT;
              r_cnt       <= '0;
              r_rx        <= '0;
              r_miso_sr   <= r_full ? r_hold : '0;
              r_from_hold <= r_full;
            end
          end
          ST_SHIFT: begin
            if (w_sck_rise) begin
              r_rx  <= w_word;
              r_cnt <= r_cnt + 1'b1;
              if (w_last) begin
                r_state <= ST_DONE;
                if (w_word != POLL) begin
                  if (r_cmd_valid && !cmd_ready) begin
                    r_overrun <= 1'b1;
                  end else begin
                    r_cmd_data  <= w_word;
                    r_cmd_valid <= 1'b1;
                  end
                end
              end
            end else if (w_sck_fall && r_cnt != '0) begin
              r_miso_sr <= {r_miso_sr[WORD_W-2:0], 1'b0};
            end
          end
          ST_DONE: ;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi_miso  = (r_state != ST_IDLE) & ~w_cs & r_miso_sr[WORD_W-1];
  assign cmd_data  = r_cmd_data;
  assign cmd_valid = r_cmd_valid;
  assign rsp_ready = r_rdy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_gigex_spi_slave.sv
// Bench for gigex_spi_slave: directed scenarios plus randomized frames.
module tb_gigex_spi_slave;

  logic        sys_clk = 1'b0;
  logic        sys_rst_mask = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sck = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        rsp_valid = 1'b0;
  logic        rsp_ready;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the response holder
  logic        m_full = 1'b0;
  logic [31:0] m_hold = '0;

  always #5 sys_clk = ~sys_clk;

  gigex_spi_slave #(
    .WORD_W     (32),
    .SYNC_STAGES(2)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_mask(sys_rst_mask),
    .spi_cs      (spi_cs),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .rsp_data    (rsp_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .overrun     (overrun)
  );

  // Master side: drive nbits of tx MSB first, capture miso on each sck rise.
  task automatic spi_bits(input logic [31:0] tx, input int nbits,
                          output logic [31:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_sck  = 1'b0;
      spi_mosi = tx[31-i];
      #60;
      spi_sck = 1'b1;
      rx = {rx[30:0], spi_miso};
      #60;
    end
  endtask

  // Full or partial frame; the model decides the expected miso word.
  task automatic spi_frame(input logic [31:0] tx, input int nbits,
                           output logic [31:0] rx, output logic [31:0] exp);
    @(negedge sys_clk);
    exp = m_full ? m_hold : 32'h0;
    spi_cs = 1'b0;
    #100;
    spi_bits(tx, nbits, rx);
    spi_cs   = 1'b0;
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    #100;
    if (nbits == 32) begin
      if (m_full) m_full = 1'b0;
    end else begin
      exp = exp >> (32 - nbits);
    end
  endtask

  task automatic load_rsp(input logic [31:0] d);
    bit ok = 0;
    @(negedge sys_clk);
    rsp_valid = 1'b1;
    rsp_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (rsp_ready) begin
        @(posedge sys_clk);
        #1;
        ok = 1;
      end else begin
        @(negedge sys_clk);
      end
    end
    rsp_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rsp_load: rsp_ready never high, required accept of %h", d);
    end else begin
      m_full = 1'b1;
      m_hold = d;
    end
  endtask

  // Wait for cmd_valid, check the word, then handshake it away.
  task automatic accept_cmd(input string name, input logic [31:0] exp);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge sys_clk);
      seen = cmd_valid;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_valid: cmd_valid=0 required 1", name);
      return;
    end
    n_checks++;
    if (cmd_data !== exp) begin
      n_fail++;
      $display("FAIL %s_data: cmd_data=%h required %h", name, cmd_data, exp);
    end
    cmd_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    cmd_ready = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drop: cmd_valid=%b required 0", name, cmd_valid);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    #1;
    check_bit("rst_miso", spi_miso, 1'b0);
    check_bit("rst_cmd_valid", cmd_valid, 1'b0);
    check_word("rst_cmd_data", cmd_data, 32'h0);
    check_bit("rst_rsp_ready", rsp_ready, 1'b0);
    check_bit("rst_overrun", overrun, 1'b0);
    @(negedge sys_clk);
    sys_rst_mask = 1'b1;
    @(negedge sys_clk);
    check_bit("rst_rdy_after", rsp_ready, 1'b1);
    m_full = 1'b0;
  endtask

  task automatic test_cmd();
    logic [31:0] rx, exp;
    spi_frame(32'hF06404F1, 32, rx, exp);
    check_word("cmd_miso", rx, 32'h0);
    repeat (5) @(negedge sys_clk);
    check_bit("cmd_hold", cmd_valid, 1'b1);
    accept_cmd("cmd", 32'hF06404F1);
  endtask

  task automatic test_poll_rsp();
    logic [31:0] rx, exp;
    load_rsp(32'hF130ABCD);
    check_bit("poll_rdy_full", rsp_ready, 1'b0);
    spi_frame(32'h0, 32, rx, exp);
    check_word("poll_miso", rx, 32'hF130ABCD);
    check_bit("poll_no_cmd", cmd_valid, 1'b0);
    check_bit("poll_rdy_back", rsp_ready, 1'b1);
  endtask

  task automatic test_overrun();
    logic [31:0] rx, exp;
    spi_frame(32'hF0300000, 32, rx, exp);
    spi_frame(32'hF0640000, 32, rx, exp);
    check_bit("ovr_flag", overrun, 1'b1);
    accept_cmd("ovr", 32'hF0300000);
    check_bit("ovr_sticky", overrun, 1'b1);
  endtask

  task automatic test_abort();
    logic [31:0] rx, exp;
    load_rsp(32'h12345678);
    spi_frame(32'hFFFFFFFF, 12, rx, exp);
    check_word("abort_miso", rx, 32'h123);
    check_bit("abort_no_cmd", cmd_valid, 1'b0);
    check_bit("abort_held", rsp_ready, 1'b0);
    spi_frame(32'h0, 32, rx, exp);
    check_word("abort_next", rx, 32'h12345678);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rx, exp;
    load_rsp(32'hCAFEF00D);
    @(negedge sys_clk);
    spi_cs = 1'b0;
    #100;
    spi_bits(32'hFFFF0000, 10, rx);
    sys_rst_mask = 1'b0;
    #5;
    check_bit("mid_miso", spi_miso, 1'b0);
    check_bit("mid_cmd_valid", cmd_valid, 1'b0);
    check_word("mid_cmd_data", cmd_data, 32'h0);
    check_bit("mid_rsp_ready", rsp_ready, 1'b0);
    check_bit("mid_overrun", overrun, 1'b0);
    m_full = 1'b0;
    @(negedge sys_clk);
    sys_rst_mask = 1'b1;
    @(negedge sys_clk);
    check_bit("mid_rdy_after", rsp_ready, 1'b1);
    #5;
    spi_bits(32'hFFFF0000, 22, rx);
    spi_cs = 1'b1;
    spi_mosi = 1'b0;
    #100;
    check_bit("mid_ignored", cmd_valid, 1'b0);
    spi_frame(32'h0000ABCD, 32, rx, exp);
    check_word("mid_miso_next", rx, 32'h0);
    accept_cmd("mid_next", 32'h0000ABCD);
  endtask

  task automatic test_random();
    logic [31:0] tx, rx, exp;
    int nbits;
    for (int it = 0; it < 14; it++) begin
      if (!m_full && $urandom_range(0, 1) == 1) load_rsp($urandom);
      tx    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      nbits = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 31) : 32;
      spi_frame(tx, nbits, rx, exp);
      check_word("rnd_miso", rx, exp);
      check_bit("rnd_rdy", rsp_ready, !m_full);
      if (nbits == 32 && tx != 32'h0) accept_cmd("rnd", tx);
      else check_bit("rnd_no_cmd", cmd_valid, 1'b0);
    end
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    test_reset();
    test_cmd();
    test_poll_rsp();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gigex_spi_slave.md
GIGEX_SPI_SLAVE -- requirements
Module: gigex_spi_slave

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning SPI frame length in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for cs/sck/mosi.
REQ-003 SHALL have port sys_clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst_mask  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port spi_cs  input  1  chip select from GigEx, active-low, asynchronous to sys_clk.
REQ-006 SHALL have port spi_sck  input  1  SPI clock from GigEx, idles high, asynchronous.
REQ-007 SHALL have port spi_mosi  input  1  serial data from GigEx, MSB first.
REQ-008 SHALL have port spi_miso  output  1  serial data to GigEx, MSB first.
REQ-009 SHALL have port cmd_data  output  WORD_W  last completed non-poll command word.
REQ-010 SHALL have ports cmd_valid output 1 / cmd_ready input 1, the command handshake; transfer when both high on a sys_clk edge.
REQ-011 SHALL have port rsp_data  input  WORD_W  response word to return on the next frame.
REQ-012 SHALL have ports rsp_valid input 1 / rsp_ready output 1, the response handshake.
REQ-013 SHALL have port overrun  output  1  sticky flag: a command was dropped.

Function
REQ-014 SHALL pass spi_cs, spi_sck, spi_mosi through SYNC_STAGES flops, then detect sck rise/fall and cs fall/rise from the last two synchronized samples.
REQ-015 SHALL operate correctly when each sck high and low phase lasts at least one sys_clk period (GigEx SCK 35 MHz, sys_clk 90 MHz).
REQ-016 SHALL implement FSM IDLE -> SHIFT on cs fall; SHIFT -> DONE on the WORD_W-th sck rise; DONE -> IDLE on cs rise; any state -> IDLE on cs rise.
REQ-017 SHALL, on cs fall, load the MISO shift register with the held response word (or all zeros if none held) and clear the bit counter.
REQ-018 SHALL sample mosi into the receive shift register on each synchronized sck rise in SHIFT, incrementing the bit counter.
REQ-019 SHALL shift the MISO register left one bit on each synchronized sck fall in SHIFT after the first rise; spi_miso = register MSB.
REQ-020 SHALL drive spi_miso low whenever cs is deasserted.
REQ-021 SHALL, on entry to DONE, forward the received word as cmd_data with cmd_valid high the next cycle, unless the word is all zeros (poll), which is not forwarded.
REQ-022 SHALL hold cmd_valid and cmd_data stable until cmd_ready; cmd_valid drops the cycle after the handshake.
REQ-023 SHALL, if a new non-poll word completes while cmd_valid is still high, drop the new word, keep the old, and set overrun until reset.
REQ-024 SHALL discard the received bits when cs rises before WORD_W rises (aborted frame); no cmd_valid, response not consumed.
REQ-025 SHALL hold one response word; rsp_ready high when the holder is empty; load on rsp_valid & rsp_ready.
REQ-026 SHALL empty the response holder only when a full WORD_W frame completes that was loaded from it.
REQ-027 SHALL, when cs falls and rsp_valid & rsp_ready occur in the same cycle, shift out zeros for that frame and keep the new word for the next frame.
REQ-028 SHALL ignore sck edges while in IDLE or DONE; extra rises beyond WORD_W are ignored.

Reset
REQ-029 SHALL, while sys_rst_mask low, force FSM IDLE, all shift registers and counters 0, spi_miso 0, cmd_valid 0, cmd_data 0, rsp_ready 0, overrun 0, holder empty; synchronizers preset to cs=1, sck=1.
REQ-030 SHALL raise rsp_ready the first cycle after reset release; a frame in progress at release is ignored until the next cs fall.

Structure
REQ-031 SHALL take SPI_WORD_W (32) and SPI_POLL_WORD (32'h0) from the shared backend_pkg package.
REQ-032 SHALL instantiate sub-module sync_bits (parameterized width/depth, preset value) for the three SPI inputs.

Verification
REQ-033 Frame 0xF06404F1 -> cmd_data=0xF06404F1, cmd_valid held until cmd_ready; spi_miso returned 0x00000000.
REQ-034 Load rsp 0xF130ABCD, then poll frame 0x00000000 -> master reads 0xF130ABCD, no cmd_valid, rsp_ready returns high after frame.
REQ-035 cmd_ready low, frames 0xF0300000 then 0xF0640000 -> cmd_data stays 0xF0300000, overrun=1.
REQ-036 cs rises after 12 bits of 0xFFFFFFFF with rsp 0x12345678 held -> no cmd_valid; next full poll returns 0x12345678.
REQ-037 sys_rst_mask pulsed low mid-frame -> all outputs at reset values; next full frame 0x0000ABCD delivered correctly.
